// File: rtl/addsub_pkg.sv
// Shared types and flag helpers for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addsub_state_t;

  function automatic logic sov_add(input logic sa, input logic sb, input logic sr);
    return (!sa & !sb & sr) | (sa & sb & !sr);
  endfunction

  function automatic logic sov_sub(input logic sa, input logic sb, input logic sr);
    return (sa & !sb & !sr) | (!sa & sb & sr);
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Request/response bundle between a controller and the add/subtract sequencer.
interface addsub_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  import addsub_pkg::*;

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         unsigned_overflow;
  logic         signed_overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, unsigned_overflow, signed_overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, unsigned_overflow, signed_overflow
  );

endinterface

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/subtract slice; subtraction relies on cin = 1 from the caller.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_eff;

  assign b_eff     = sub ? ~b : b;
  assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract: one 4-bit slice stepped LSB-first over NIBBLES nibbles,
// carry chained through a register, flags taken from the final step.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_seq_if.slave bus
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  addsub_state_t state_q, state_d;

  // Operands and result viewed as nibble arrays so the step index selects a slice directly.
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            uov_q, uov_d, sov_q, sov_d;

  logic [NIBBLE_W-1:0] s;
  logic                cout;

  nibble_addsub u_slice (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .sub (sub_q),
    .cin (carry_q),
    .s   (s),
    .cout(cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    uov_d    = uov_q;
    sov_d    = sov_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          idx_d   = '0;
          carry_d = bus.sub;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[idx_q] = s;
        carry_d         = cout;
        idx_d           = idx_q + 1'b1;
        busy_d          = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          uov_d   = sub_q ? !cout : cout;
          sov_d   = sub_q ? sov_sub(a_q[NIBBLES-1][NIBBLE_W-1], b_q[NIBBLES-1][NIBBLE_W-1], s[NIBBLE_W-1])
                          : sov_add(a_q[NIBBLES-1][NIBBLE_W-1], b_q[NIBBLES-1][NIBBLE_W-1], s[NIBBLE_W-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      uov_q    <= 1'b0;
      sov_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      uov_q    <= uov_d;
      sov_q    <= sov_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.result            = result_q;
  assign bus.unsigned_overflow = uov_q;
  assign bus.signed_overflow   = sov_q;

endmodule
